// File: rtl/aes_serial_pkg.sv
// rtl/aes_serial_pkg.sv - shared types and byte-placement helpers for the byte-serial AES datapath
package aes_serial_pkg;

  // One AES state is 16 bytes, column-major: byte i sits at row i%4, column i/4.
  localparam int NUM_BYTES = 16;

  typedef logic [3:0] byte_idx_t;
  typedef logic [4:0] byte_cnt_t;

  // Counter value meaning "all 16 bytes issued" and the index of the last byte.
  localparam byte_cnt_t CNT_FULL  = byte_cnt_t'(NUM_BYTES);
  localparam byte_cnt_t CNT_LAST  = byte_cnt_t'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  // Destination byte index of source byte src after (Inv)ShiftRows.
  // Encrypt rotates row r left by r columns, decrypt rotates it right;
  // the 2-bit column arithmetic wraps mod 4 by construction.
  function automatic byte_idx_t sr_dst(input byte_idx_t src,
                                       input logic      encrypt,
                                       input logic      shift_en);
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] dst_col;
    row = src[1:0];
    col = src[3:2];
    if (!shift_en) begin
      dst_col = col;
    end else if (encrypt) begin
      dst_col = col - row;
    end else begin
      dst_col = col + row;
    end
    return {dst_col, row};
  endfunction

  // Byte i of a 128-bit state lives in bits [127-8i -: 8]; in a packed
  // [15:0][7:0] view that is element 15-i, which for a 4-bit index is ~i.
  function automatic byte_idx_t byte_slot(input byte_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/aes_sr_index_delay.sv
// rtl/aes_sr_index_delay.sv - valid+byte-index delay line matching the external S-box latency
module aes_sr_index_delay #(
  parameter int LAT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  aes_serial_pkg::byte_idx_t in_idx,
  output logic                      out_valid,
  output aes_serial_pkg::byte_idx_t out_idx
);
  import aes_serial_pkg::*;

  generate
    if (LAT == 0) begin : g_wire
      // Combinational S-box: the result belongs to the byte issued this cycle.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid      = in_valid;
      assign out_idx        = in_idx;
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      byte_idx_t      idx_q [LAT];

      // Shift the issued index along with the S-box pipeline so write-back
      // sees the index that produced the current sbox_q.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) begin
            idx_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= in_valid;
          idx_q[0] <= in_idx;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      assign out_valid = vld_q[LAT-1];
      assign out_idx   = idx_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/aes_subbytes_sequencer.sv
// rtl/aes_subbytes_sequencer.sv - byte-serial SubBytes/ShiftRows stage around an external S-box
module aes_subbytes_sequencer #(
  parameter int SBOX_LAT   = 0,
  parameter int SHIFT_ROWS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_encrypt,
  output logic [7:0]   sbox_a,
  output logic         sbox_encrypt,
  input  logic [7:0]   sbox_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  import aes_serial_pkg::*;

  localparam logic SHIFT_EN = (SHIFT_ROWS != 0);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [15:0][7:0] state_reg;
  logic [15:0][7:0] result_reg;
  // Stored inverted so that the reset value 0 presents encrypt mode to the S-box.
  logic             mode_dec_q;

  byte_cnt_t rd_cnt;
  byte_cnt_t wr_cnt;
  logic [7:0] sbox_a_q;
  logic [7:0] sbox_a_d;

  logic      accept;
  logic      rd_valid;
  byte_idx_t rd_idx;
  logic      wr_valid;
  logic      wr_en;
  logic      wr_last;
  byte_idx_t wr_idx;
  byte_idx_t wr_dst;

  assign accept   = in_valid & in_ready;
  assign rd_valid = (state_q == SEQ_RUN) && (rd_cnt != CNT_FULL);
  assign rd_idx   = rd_cnt[3:0];

  aes_sr_index_delay #(
    .LAT (SBOX_LAT)
  ) u_idx_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_valid),
    .in_idx    (rd_idx),
    .out_valid (wr_valid),
    .out_idx   (wr_idx)
  );

  // Writes complete in issue order, so the write count identifies the last byte.
  assign wr_en   = wr_valid && (state_q == SEQ_RUN);
  assign wr_last = wr_en && (wr_cnt == CNT_LAST);
  assign wr_dst  = sr_dst(wr_idx, ~mode_dec_q, SHIFT_EN);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept -> issue/write 16 bytes -> hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: if (accept)    state_d = SEQ_RUN;
      SEQ_RUN:  if (wr_last)   state_d = SEQ_DONE;
      SEQ_DONE: if (out_ready) state_d = SEQ_IDLE;
      default:                 state_d = SEQ_IDLE;
    endcase
  end

  // FSM outputs: handshakes and busy flag decode straight from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      SEQ_IDLE: in_ready  = 1'b1;
      SEQ_RUN:  busy      = 1'b1;
      SEQ_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default:  in_ready  = 1'b0;
    endcase
  end

  // S-box address: current source byte while issuing, otherwise hold the last one.
  always_comb begin
    sbox_a_d = sbox_a_q;
    if (rd_valid) begin
      sbox_a_d = state_reg[byte_slot(rd_idx)];
    end
  end

  assign sbox_a       = sbox_a_d;
  assign sbox_encrypt = ~mode_dec_q;
  assign out_data     = result_reg;

  // Datapath: latch the block on accept, step the issue counter, place S-box results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= '0;
      result_reg <= '0;
      mode_dec_q <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      sbox_a_q   <= '0;
    end else begin
      sbox_a_q <= sbox_a_d;
      if (accept) begin
        state_reg  <= in_data;
        mode_dec_q <= ~in_encrypt;
        rd_cnt     <= '0;
        wr_cnt     <= '0;
      end else begin
        if (rd_valid) begin
          rd_cnt <= rd_cnt + 5'd1;
        end
        if (wr_en) begin
          result_reg[byte_slot(wr_dst)] <= sbox_q;
          wr_cnt                        <= wr_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_subbytes_sequencer.sv
// tb/tb_aes_subbytes_sequencer.sv - randomized bench for aes_subbytes_sequencer with a GF(2^8) S-box reference
module tb_aes_subbytes_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_encrypt;
  logic         out_ready;

  // dut0: combinational S-box, ShiftRows on
  logic         ir0, ov0, se0, b0;
  logic [7:0]   sa0, q0;
  logic [127:0] od0;
  // dut3: 3-stage S-box, ShiftRows on
  logic         ir3, ov3, se3, b3;
  logic [7:0]   sa3, q3;
  logic [127:0] od3;
  // dutn: combinational S-box, identity placement
  logic         irn, ovn, sen, bn;
  logic [7:0]   san, qn;
  logic [127:0] odn;

  logic [7:0] sb_fwd [256];
  logic [7:0] sb_inv [256];
  logic [7:0] p3 [3];

  int total = 0;
  int bad   = 0;

  logic [127:0] cur_d;
  logic         cur_enc;
  logic [127:0] last0, last3, lastn;

  always #5 clk = ~clk;

  aes_subbytes_sequencer #(.SBOX_LAT(0), .SHIFT_ROWS(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_encrypt(in_encrypt), .sbox_a(sa0), .sbox_encrypt(se0), .sbox_q(q0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .busy(b0));

  aes_subbytes_sequencer #(.SBOX_LAT(3), .SHIFT_ROWS(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .in_encrypt(in_encrypt), .sbox_a(sa3), .sbox_encrypt(se3), .sbox_q(q3),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .busy(b3));

  aes_subbytes_sequencer #(.SBOX_LAT(0), .SHIFT_ROWS(0)) dutn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irn), .in_data(in_data),
    .in_encrypt(in_encrypt), .sbox_a(san), .sbox_encrypt(sen), .sbox_q(qn),
    .out_valid(ovn), .out_ready(out_ready), .out_data(odn), .busy(bn));

  // Bench S-boxes: combinational for dut0/dutn, three register stages for dut3.
  always_comb q0 = se0 ? sb_fwd[sa0] : sb_inv[sa0];
  always_comb qn = sen ? sb_fwd[san] : sb_inv[san];
  always @(posedge clk) begin
    p3[0] <= se3 ? sb_fwd[sa3] : sb_inv[sa3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign q3 = p3[2];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb_fwd[x] = s;
      sb_inv[s] = 8'(x);
    end
  endtask

  // Reference: substitute every byte, then gather each output cell from its row rotation.
  function automatic logic [127:0] ref_model(input logic [127:0] d, input logic enc, input logic shift);
    logic [7:0]   sb [4][4];
    logic [7:0]   b;
    logic [127:0] o = '0;
    int           sc;
    for (int i = 0; i < 16; i++) begin
      b = d[127 - 8*i -: 8];
      sb[i % 4][i / 4] = enc ? sb_fwd[b] : sb_inv[b];
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!shift)   sc = c;
        else if (enc) sc = (c + r) % 4;
        else          sc = (c - r + 4) % 4;
        o[127 - 8*(4*c + r) -: 8] = sb[r][sc];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_block(input logic [127:0] d, input logic enc);
    @(negedge clk);
    chk("in_ready_pre", {ir0, ir3, irn}, 3'b111);
    in_data    = d;
    in_encrypt = enc;
    in_valid   = 1'b1;
    cur_d      = d;
    cur_enc    = enc;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_encrypt = ~enc;
    in_data    = rnd128();
  endtask

  task automatic finish_block(input int hold);
    logic [127:0] seq0 = '0;
    logic [127:0] seq3 = '0;
    logic [127:0] e0, en;
    int lat0 = -1;
    int lat3 = -1;
    int latn = -1;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (n < 16) begin
        seq0 = {seq0[119:0], sa0};
        seq3 = {seq3[119:0], sa3};
      end
      if (n == 2) out_ready = 1'b1;
      if (n == 5) chk("sbox_encrypt", {se0, se3, sen}, {3{cur_enc}});
      if (n == 10) begin
        chk("busy_run", {b0, b3, bn, ov0, ov3, ovn}, 6'b111000);
        out_ready = 1'b0;
      end
      if (ov0 && lat0 < 0) lat0 = n;
      if (ov3 && lat3 < 0) lat3 = n;
      if (ovn && latn < 0) latn = n;
      if (lat0 >= 0 && lat3 >= 0 && latn >= 0) break;
    end
    chk("lat0", lat0, 16);
    chk("lat3", lat3, 19);
    chk("latn", latn, 16);
    chk("sbox_a_seq0", seq0, cur_d);
    chk("sbox_a_seq3", seq3, cur_d);
    e0 = ref_model(cur_d, cur_enc, 1'b1);
    en = ref_model(cur_d, cur_enc, 1'b0);
    chk("out0", od0, e0);
    chk("out3", od3, e0);
    chk("outn", odn, en);
    last0 = od0;
    last3 = od3;
    lastn = odn;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rnd128();
      @(posedge clk);
      #1;
      chk("hold_data", {od0 ^ last0, od3 ^ last3, odn ^ lastn}, '0);
      chk("hold_hs", {ir0, ir3, irn, ov0, ov3, ovn}, 6'b000111);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after", {ov0, ov3, ovn, b0, b3, bn, ir0, ir3, irn}, 9'b000000111);
  endtask

  localparam logic [127:0] V1 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1 = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] V3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_encrypt = 1'b0;
    out_ready  = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hs", {ir0, ov0, b0, ir3, ov3, b3}, 6'b100100);
    chk("rst_sbox", {sa0, se0, sa3, se3}, {8'h00, 1'b1, 8'h00, 1'b1});
    chk("rst_out", od0 | od3 | odn, '0);

    // directed vectors
    start_block(V1, 1'b1);
    finish_block(10);
    chk("v1_enc0", last0, C1);
    chk("v1_enc3", last3, C1);
    start_block(C1, 1'b0);
    finish_block(0);
    chk("v1_dec0", last0, V1);
    chk("v1_dec3", last3, V1);
    start_block(V3, 1'b1);
    finish_block(2);
    chk("v3_noshift", lastn, C3);

    // reset while issuing byte 7
    start_block(rnd128(), 1'b1);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_run", {ov0, b0, ov3, b3, ir0, ir3}, 6'b000011);
    @(negedge clk);
    rst = 1'b0;
    start_block(V1, 1'b1);
    finish_block(0);
    chk("post_rst0", last0, C1);
    chk("post_rst3", last3, C1);

    // reset while holding a result
    start_block(rnd128(), 1'b0);
    for (int k = 0; k < 30 && !ov0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("done_reach", ov0, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_done", {ov0, b0, ir0}, 3'b001);
    chk("rst_done_data", od0, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;

    // random blocks
    for (int t = 0; t < 20; t++) begin
      start_block(rnd128(), 1'($urandom_range(0, 1)));
      finish_block(int'($urandom_range(0, 5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
